// File: rtl/guess_grader_n_if.sv
// Bundle of the guess-entry, control and result signals of guess_grader_n.
// "master" drives the codes and controls; "slave" is the grading engine.
interface guess_grader_n_if #(
  parameter int NUM_PEGS   = 4,
  parameter int SYM_W      = 3,
  parameter int MAX_ROUNDS = 8
);
  localparam int CNT_W = $clog2(NUM_PEGS + 1);
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);

  logic [NUM_PEGS*SYM_W-1:0] Guess;
  logic [NUM_PEGS*SYM_W-1:0] Master;
  logic                      GradeIt;
  logic                      gamePlaying;
  logic                      clear;
  logic [CNT_W-1:0]          Znarly;
  logic [CNT_W-1:0]          Zood;
  logic [RND_W-1:0]          RoundNumber;
  logic                      GameWon;
  logic                      GameOver;
  logic                      busy;
  logic                      gradeValid;

  modport master (
    output Guess, Master, GradeIt, gamePlaying, clear,
    input  Znarly, Zood, RoundNumber, GameWon, GameOver, busy, gradeValid
  );

  modport slave (
    input  Guess, Master, GradeIt, gamePlaying, clear,
    output Znarly, Zood, RoundNumber, GameWon, GameOver, busy, gradeValid
  );
endinterface

// File: rtl/guess_grader_n.sv
// Zood/Znarly guess grader: exact matches in one cycle, then a one-peg-per-cycle
// walk that claims the lowest free master peg for each non-exact guess peg.
//
// state  | meaning
// IDLE   | waiting for a GradeIt rising edge
// LOAD   | capture Guess and Master
// ZNARLY | compute exact matches and their count
// ZOOD   | scan guess peg k for a free wrong-position match
// DONE   | publish results, bump round, pulse gradeValid
module guess_grader_n #(
  parameter int NUM_PEGS   = 4,
  parameter int SYM_W      = 3,
  parameter int MAX_ROUNDS = 8
) (
  input logic             CLOCK_50,
  input logic             reset_n,
  guess_grader_n_if.slave bus
);
  localparam int CNT_W  = $clog2(NUM_PEGS + 1);
  localparam int RND_W  = $clog2(MAX_ROUNDS + 1);
  localparam int K_W    = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
  localparam int CODE_W = NUM_PEGS * SYM_W;

  typedef enum logic [2:0] {IDLE, LOAD, ZNARLY, ZOOD, DONE} state_t;

  state_t              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic [CODE_W-1:0]   g_q, g_d, m_q, m_d;
  logic [NUM_PEGS-1:0] exact_q, exact_d, claimed_q, claimed_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]    znarly_acc_q, znarly_acc_d, zood_acc_q, zood_acc_d;
  logic [CNT_W-1:0]    znarly_q, znarly_d, zood_q, zood_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic                won_q, won_d, valid_q, valid_d;
  logic                game_over, busy, req;
  logic [SYM_W-1:0]    g_k;
  logic                exact_k, hit;
  logic [NUM_PEGS-1:0] hit_onehot;

  assign game_over = won_q | (round_q == RND_W'(MAX_ROUNDS));
  assign busy      = (state_q != IDLE);
  assign req       = s2_q & ~s3_q & bus.gamePlaying & ~game_over & ~busy;

  // Lowest unclaimed master peg whose symbol equals guess peg k.
  always_comb begin
    g_k        = '0;
    exact_k    = 1'b0;
    hit        = 1'b0;
    hit_onehot = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (k_q == K_W'(i)) begin
        g_k     = g_q[i*SYM_W +: SYM_W];
        exact_k = exact_q[i];
      end
    end
    for (int j = 0; j < NUM_PEGS; j++) begin
      if (!hit && !claimed_q[j] && (m_q[j*SYM_W +: SYM_W] == g_k)) begin
        hit           = 1'b1;
        hit_onehot[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    m_d          = m_q;
    exact_d      = exact_q;
    claimed_d    = claimed_q;
    k_d          = k_q;
    znarly_acc_d = znarly_acc_q;
    zood_acc_d   = zood_acc_q;
    znarly_d     = znarly_q;
    zood_d       = zood_q;
    round_d      = round_q;
    won_d        = won_q;
    valid_d      = 1'b0;

    case (state_q)
      IDLE: if (req) state_d = LOAD;
      LOAD: begin
        g_d     = bus.Guess;
        m_d     = bus.Master;
        state_d = ZNARLY;
      end
      ZNARLY: begin
        znarly_acc_d = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
          exact_d[i]   = (g_q[i*SYM_W +: SYM_W] == m_q[i*SYM_W +: SYM_W]);
          znarly_acc_d = znarly_acc_d + CNT_W'(exact_d[i]);
        end
        claimed_d  = exact_d;
        zood_acc_d = '0;
        k_d        = '0;
        state_d    = ZOOD;
      end
      ZOOD: begin
        if (!exact_k && hit) begin
          claimed_d  = claimed_q | hit_onehot;
          zood_acc_d = zood_acc_q + CNT_W'(1);
        end
        if (k_q == K_W'(NUM_PEGS - 1)) state_d = DONE;
        else                           k_d     = k_q + K_W'(1);
      end
      DONE: begin
        znarly_d = znarly_acc_q;
        zood_d   = zood_acc_q;
        if (round_q != RND_W'(MAX_ROUNDS)) round_d = round_q + RND_W'(1);
        if (znarly_acc_q == CNT_W'(NUM_PEGS)) won_d = 1'b1;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over everything but leaves the GradeIt synchroniser alone.
    if (bus.clear) begin
      state_d      = IDLE;
      k_d          = '0;
      znarly_acc_d = '0;
      zood_acc_d   = '0;
      znarly_d     = '0;
      zood_d       = '0;
      round_d      = '0;
      won_d        = 1'b0;
      valid_d      = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      g_q          <= '0;
      m_q          <= '0;
      exact_q      <= '0;
      claimed_q    <= '0;
      k_q          <= '0;
      znarly_acc_q <= '0;
      zood_acc_q   <= '0;
      znarly_q     <= '0;
      zood_q       <= '0;
      round_q      <= '0;
      won_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= bus.GradeIt;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      g_q          <= g_d;
      m_q          <= m_d;
      exact_q      <= exact_d;
      claimed_q    <= claimed_d;
      k_q          <= k_d;
      znarly_acc_q <= znarly_acc_d;
      zood_acc_q   <= zood_acc_d;
      znarly_q     <= znarly_d;
      zood_q       <= zood_d;
      round_q      <= round_d;
      won_q        <= won_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.Znarly      = znarly_q;
  assign bus.Zood        = zood_q;
  assign bus.RoundNumber = round_q;
  assign bus.GameWon     = won_q;
  assign bus.GameOver    = game_over;
  assign bus.busy        = busy;
  assign bus.gradeValid  = valid_q;
endmodule

// File: tb/tb_guess_grader_n.sv
// Bench for guess_grader_n: a 4-peg/3-bit and a 6-peg/4-bit instance, checked
// against a symbol-count model of the game rules plus timing sequences.
module tb_guess_grader_n;
  localparam int MAXR = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  int          sel;
  logic [23:0] guess_w, master_w;
  logic        grade_it, playing, clear_w;
  int          o_zn, o_zo, o_rnd, o_won, o_over, o_busy, o_gv;
  int          vectors = 0;
  int          miscompares = 0;
  int          ga[6];
  int          ma[6];

  always #5 CLOCK_50 = ~CLOCK_50;

  guess_grader_n_if #(.NUM_PEGS(4), .SYM_W(3), .MAX_ROUNDS(MAXR)) bus4 ();
  guess_grader_n_if #(.NUM_PEGS(6), .SYM_W(4), .MAX_ROUNDS(MAXR)) bus6 ();

  guess_grader_n #(.NUM_PEGS(4), .SYM_W(3), .MAX_ROUNDS(MAXR)) dut4 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus4));
  guess_grader_n #(.NUM_PEGS(6), .SYM_W(4), .MAX_ROUNDS(MAXR)) dut6 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus6));

  assign bus4.Guess       = guess_w[11:0];
  assign bus4.Master      = master_w[11:0];
  assign bus4.GradeIt     = grade_it && (sel == 0);
  assign bus4.clear       = clear_w && (sel == 0);
  assign bus4.gamePlaying = playing;
  assign bus6.Guess       = guess_w;
  assign bus6.Master      = master_w;
  assign bus6.GradeIt     = grade_it && (sel == 1);
  assign bus6.clear       = clear_w && (sel == 1);
  assign bus6.gamePlaying = playing;

  always_comb begin
    if (sel == 0) begin
      o_zn = int'(bus4.Znarly);  o_zo = int'(bus4.Zood);  o_rnd = int'(bus4.RoundNumber);
      o_won = int'(bus4.GameWon); o_over = int'(bus4.GameOver);
      o_busy = int'(bus4.busy);  o_gv = int'(bus4.gradeValid);
    end else begin
      o_zn = int'(bus6.Znarly);  o_zo = int'(bus6.Zood);  o_rnd = int'(bus6.RoundNumber);
      o_won = int'(bus6.GameWon); o_over = int'(bus6.GameOver);
      o_busy = int'(bus6.busy);  o_gv = int'(bus6.gradeValid);
    end
  end

  typedef struct {
    int          sel;
    logic [23:0] g;
    logic [23:0] m;
    int          zn;
    int          zo;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int npegs();
    return (sel == 0) ? 4 : 6;
  endfunction

  // Rules model: exact matches, then per-symbol min of the leftover counts.
  function automatic void model(output int zn, output int zo);
    int cg[16];
    int cm[16];
    zn = 0;
    zo = 0;
    for (int s = 0; s < 16; s++) begin cg[s] = 0; cm[s] = 0; end
    for (int i = 0; i < npegs(); i++) begin
      if (ga[i] == ma[i]) zn++;
      else begin cg[ga[i]]++; cm[ma[i]]++; end
    end
    for (int s = 0; s < 16; s++) zo += (cg[s] < cm[s]) ? cg[s] : cm[s];
  endfunction

  task automatic set_codes();
    int w;
    w = (sel == 0) ? 3 : 4;
    guess_w  = '0;
    master_w = '0;
    for (int i = 0; i < npegs(); i++) begin
      guess_w  = guess_w  | (24'(ga[i]) << (i * w));
      master_w = master_w | (24'(ma[i]) << (i * w));
    end
  endtask

  task automatic do_clear();
    clear_w = 1'b1;
    @(posedge CLOCK_50); #1;
    clear_w = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_zn"}, o_zn, 0);
    chk({name, "_zo"}, o_zo, 0);
    chk({name, "_rnd"}, o_rnd, 0);
    chk({name, "_won"}, o_won, 0);
    chk({name, "_over"}, o_over, 0);
    chk({name, "_busy"}, o_busy, 0);
    chk({name, "_gv"}, o_gv, 0);
  endtask

  // One GradeIt pulse, then watch busy/gradeValid timing and the results.
  task automatic grade(input string name, input int ezn, input int ezo,
                       input int erd, input int ewon, input bit repulse);
    int n, gv_cnt, gv_at, b_first, b_last, rnd_at_gv;
    n = npegs();
    gv_cnt = 0; gv_at = -1; b_first = -1; b_last = -1; rnd_at_gv = -1;
    grade_it = 1'b1;
    for (int c = 0; c < n + 9; c++) begin
      @(posedge CLOCK_50); #1;
      if (o_gv != 0) begin gv_cnt++; gv_at = c; rnd_at_gv = o_rnd; end
      if (o_busy != 0) begin
        if (b_first < 0) b_first = c;
        b_last = c;
      end
      if (c == 1) grade_it = 1'b0;
      if (c == 3) begin
        guess_w  = 24'($urandom);
        master_w = 24'($urandom);
        if (repulse) grade_it = 1'b1;
        else         playing  = 1'b0;
      end
      if (c == 5) grade_it = 1'b0;
      if (c == n + 6) playing = 1'b1;
    end
    chk({name, "_gv_count"}, gv_cnt, 1);
    chk({name, "_gv_edge"}, gv_at, n + 5);
    chk({name, "_busy_rise"}, b_first, 2);
    chk({name, "_busy_last"}, b_last, n + 4);
    chk({name, "_rnd_at_gv"}, rnd_at_gv, erd);
    chk({name, "_zn"}, o_zn, ezn);
    chk({name, "_zo"}, o_zo, ezo);
    chk({name, "_rnd"}, o_rnd, erd);
    chk({name, "_won"}, o_won, ewon);
    chk({name, "_over"}, o_over, (ewon != 0 || erd == MAXR) ? 1 : 0);
  endtask

  task automatic ignored(input string name, input int ezn, input int ezo, input int erd);
    int act;
    act = 0;
    grade_it = 1'b1;
    for (int c = 0; c < npegs() + 9; c++) begin
      @(posedge CLOCK_50); #1;
      if (o_busy != 0 || o_gv != 0) act++;
      if (c == 1) grade_it = 1'b0;
    end
    chk({name, "_activity"}, act, 0);
    chk({name, "_zn"}, o_zn, ezn);
    chk({name, "_zo"}, o_zo, ezo);
    chk({name, "_rnd"}, o_rnd, erd);
  endtask

  task automatic rand_codes(input bit no_win);
    int r;
    bit same;
    r = (sel == 0) ? 8 : 16;
    for (int i = 0; i < 6; i++) begin ga[i] = 0; ma[i] = 0; end
    for (int i = 0; i < npegs(); i++) ma[i] = int'($urandom_range(r - 1));
    for (int i = 0; i < npegs(); i++)
      ga[i] = ($urandom_range(1) == 1) ? ma[$urandom_range(npegs() - 1)] : int'($urandom_range(r - 1));
    same = 1'b1;
    for (int i = 0; i < npegs(); i++) if (ga[i] != ma[i]) same = 1'b0;
    if (no_win && same) ga[0] = (ma[0] + 1) % r;
  endtask

  initial begin
    int zn, zo, gv_seen;
    reset_n = 1'b0; sel = 0; grade_it = 1'b0; playing = 1'b1; clear_w = 1'b0;
    guess_w = '0; master_w = '0;
    for (int i = 0; i < 6; i++) begin ga[i] = 0; ma[i] = 0; end

    tbl[0]  = '{0, 24'h005231, 24'h004321, 1, 2};
    tbl[1]  = '{0, 24'h001121, 24'h002211, 1, 2};
    tbl[2]  = '{0, 24'h007777, 24'h000000, 0, 0};
    tbl[3]  = '{0, 24'h001234, 24'h004321, 0, 4};
    tbl[4]  = '{0, 24'h006665, 24'h005555, 1, 0};
    tbl[5]  = '{0, 24'h004321, 24'h004321, 4, 0};
    tbl[6]  = '{0, 24'h002233, 24'h003322, 0, 4};
    tbl[7]  = '{0, 24'h006770, 24'h000707, 1, 2};
    tbl[8]  = '{1, 24'hCB5231, 24'hA94321, 1, 2};
    tbl[9]  = '{1, 24'hEE1121, 24'h0F2211, 1, 2};
    tbl[10] = '{1, 24'hFEDCBA, 24'hFEDCBA, 6, 0};
    tbl[11] = '{1, 24'h100000, 24'h000001, 4, 2};

    repeat (2) @(posedge CLOCK_50);
    #1;
    sel = 0; #0 chk_zero("reset4");
    sel = 1; #0 chk_zero("reset6");
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;

    for (int t = 0; t < 12; t++) begin
      sel = tbl[t].sel;
      for (int i = 0; i < 6; i++) begin
        ga[i] = int'(tbl[t].g[4*i +: 4]);
        ma[i] = int'(tbl[t].m[4*i +: 4]);
      end
      set_codes();
      do_clear();
      grade($sformatf("tbl%0d", t), tbl[t].zn, tbl[t].zo, 1,
            (tbl[t].zn == npegs()) ? 1 : 0, 1'b0);
    end

    // Three-round game ending in a win, with a re-pulse while busy.
    sel = 0;
    do_clear();
    chk_zero("clr4");
    ga = '{1, 3, 2, 5, 0, 0}; ma = '{1, 2, 3, 4, 0, 0}; set_codes();
    grade("plan_r1", 1, 2, 1, 0, 1'b0);
    ga = '{1, 2, 1, 1, 0, 0}; ma = '{1, 1, 2, 2, 0, 0}; set_codes();
    grade("plan_r2", 1, 2, 2, 0, 1'b1);
    ga = '{6, 0, 7, 3, 0, 0}; ma = '{6, 0, 7, 3, 0, 0}; set_codes();
    grade("plan_r3", 4, 0, 3, 1, 1'b0);
    ignored("after_win", 4, 0, 3);

    do_clear();
    chk_zero("clr_after_win");
    playing = 1'b0;
    ignored("not_playing", 0, 0, 0);
    playing = 1'b1;

    // Round limit: eight non-winning grades, then a ninth request is dropped.
    zn = 0; zo = 0;
    for (int r = 1; r <= MAXR; r++) begin
      rand_codes(1'b1);
      model(zn, zo);
      set_codes();
      grade($sformatf("round%0d", r), zn, zo, r, 0, 1'b0);
    end
    ignored("ninth", zn, zo, MAXR);

    // Clear while in ZOOD.
    do_clear();
    ga = '{1, 3, 2, 5, 0, 0}; ma = '{1, 2, 3, 4, 0, 0}; set_codes();
    grade("pre_clr", 1, 2, 1, 0, 1'b0);
    gv_seen = 0;
    grade_it = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge CLOCK_50); #1;
      if (o_gv != 0) gv_seen++;
      if (c == 1) grade_it = 1'b0;
      if (c == 5) begin
        chk("zood_busy", o_busy, 1);
        clear_w = 1'b1;
      end
      if (c == 6) begin
        clear_w = 1'b0;
        chk_zero("mid_clr");
      end
    end
    chk("mid_clr_no_gv", gv_seen, 0);
    chk("mid_clr_rnd_end", o_rnd, 0);

    // Random codes on both widths against the model.
    for (int t = 0; t < 24; t++) begin
      sel = t % 2;
      rand_codes(1'b0);
      model(zn, zo);
      set_codes();
      do_clear();
      grade($sformatf("rnd%0d", t), zn, zo, 1, (zn == npegs()) ? 1 : 0, 1'b0);
    end

    // Reset dropped mid-grade on the 6-peg instance.
    sel = 1;
    do_clear();
    ga = '{1, 3, 2, 5, 11, 12}; ma = '{1, 2, 3, 4, 9, 10}; set_codes();
    grade("pre_rst", 1, 2, 1, 0, 1'b0);
    grade_it = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge CLOCK_50); #1;
      if (c == 1) grade_it = 1'b0;
    end
    chk("pre_rst_busy", o_busy, 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;
    chk_zero("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
